// File: rtl/spi_master.sv
// spi_master: single-lane SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
// A request handshake latches the transfer parameters, the FSM walks the
// SPI clock through setup, data and hold phases, and the received bits are
// returned on a valid/ready response channel. Every pin and response output
// is a register, so there is no combinational path from miso to any output.
module spi_master #(
   parameter int MAX_LEN = 16,
   parameter int SS_W    = 8,
   parameter int DIV_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN)
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [MAX_LEN-1:0] req_data,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [SS_W-1:0]    req_ss,
   input  logic [DIV_W-1:0]   req_div,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               sck,
   output logic [SS_W-1:0]    ss_n,
   output logic               mosi,
   input  logic               miso
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER_HI,
      XFER_LO,
      HOLD,
      RSP
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   hc_q, hc_d;
   logic [LEN_W-1:0]   bc_q, bc_d;
   logic               lead_q, lead_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [SS_W-1:0]    ss_q, ss_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [MAX_LEN-1:0] rx_q, rx_d;
   logic               sck_q, sck_d;
   logic [SS_W-1:0]    ss_n_q, ss_n_d;
   logic               mosi_q, mosi_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               tick;
   logic [LEN_W-1:0]   bc_inc;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign sck       = sck_q;
   assign ss_n      = ss_n_q;
   assign mosi      = mosi_q;

   // Next-state and next-output logic. Pin values are computed one cycle
   // ahead so they change exactly on the edge where the phase changes.
   // SETUP spans two half-periods (lead_q) so the select is held for a full
   // sck period before the first rising edge.
   always_comb begin
      state_d     = state_q;
      hc_d        = '0;
      bc_d        = bc_q;
      lead_d      = lead_q;
      data_d      = data_q;
      len_d       = len_q;
      ss_d        = ss_q;
      div_d       = div_q;
      rx_d        = rx_q;
      sck_d       = sck_q;
      ss_n_d      = ss_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      tick        = (hc_q == div_q);
      bc_inc      = bc_q + LEN_W'(1);

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               data_d  = req_data;
               len_d   = req_len;
               ss_d    = req_ss;
               div_d   = req_div;
               rx_d    = '0;
               bc_d    = '0;
               lead_d  = 1'b1;
               sck_d   = 1'b0;
               ss_n_d  = ~req_ss;
               mosi_d  = req_data[req_len];
               state_d = SETUP;
            end
         end
         SETUP: begin
            hc_d = tick ? '0 : hc_q + DIV_W'(1);
            if (tick) begin
               if (lead_q) begin
                  lead_d = 1'b0;
               end else begin
                  sck_d   = 1'b1;
                  rx_d    = {rx_q[MAX_LEN-2:0], miso};
                  state_d = XFER_HI;
               end
            end
         end
         XFER_HI: begin
            hc_d = tick ? '0 : hc_q + DIV_W'(1);
            if (tick) begin
               sck_d = 1'b0;
               if (bc_q < len_q) begin
                  bc_d    = bc_inc;
                  mosi_d  = data_q[len_q - bc_inc];
                  state_d = XFER_LO;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         XFER_LO: begin
            hc_d = tick ? '0 : hc_q + DIV_W'(1);
            if (tick) begin
               sck_d   = 1'b1;
               rx_d    = {rx_q[MAX_LEN-2:0], miso};
               state_d = XFER_HI;
            end
         end
         HOLD: begin
            hc_d = tick ? '0 : hc_q + DIV_W'(1);
            if (tick) begin
               ss_n_d      = '1;
               mosi_d      = 1'b1;
               rsp_data_d  = rx_q;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; a low rst_n abandons any transfer at once.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hc_q        <= '0;
         bc_q        <= '0;
         lead_q      <= 1'b0;
         data_q      <= '0;
         len_q       <= '0;
         ss_q        <= '0;
         div_q       <= '0;
         rx_q        <= '0;
         sck_q       <= 1'b0;
         ss_n_q      <= '1;
         mosi_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         hc_q        <= hc_d;
         bc_q        <= bc_d;
         lead_q      <= lead_d;
         data_q      <= data_d;
         len_q       <= len_d;
         ss_q        <= ss_d;
         div_q       <= div_d;
         rx_q        <= rx_d;
         sck_q       <= sck_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master. A behavioural model
// predicts response data, mosi bit order, sck timing and latency from the
// transfer parameters; a small SPI slave drives miso from a random pattern.
module tb_spi_master;

   logic        clock;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_data;
   logic [3:0]  req_len;
   logic [7:0]  req_ss;
   logic [7:0]  req_div;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        sck;
   logic [7:0]  ss_n;
   logic        mosi;
   logic        miso;

   int checkCount = 0;
   int errorCount = 0;
   int cycleCount = 0;
   int hsCycle;

   logic [15:0] curData, curPat;
   logic [3:0]  curLen;
   logic [7:0]  curSs, curDiv;
   bit          curLoop;

   bit          loopMode;
   logic        slaveBit;
   logic [15:0] misoPat;
   int          slaveIdx;
   logic        prevSck;
   int          riseCycle[$];
   bit          riseMosi[$];
   logic [7:0]  riseSs[$];

   spi_master dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_len   (req_len),
      .req_ss    (req_ss),
      .req_div   (req_div),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso)
   );

   assign miso = loopMode ? mosi : slaveBit;

   // Free-running clock and cycle counter
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Bus monitor and slave: records each rising sck edge, and presents the
   // next pattern bit on miso after each falling sck edge.
   initial prevSck = 1'b0;
   always @(negedge clock) begin
      if (sck === 1'b1 && prevSck === 1'b0) begin
         riseCycle.push_back(cycleCount);
         riseMosi.push_back(mosi);
         riseSs.push_back(ss_n);
      end
      if (sck === 1'b0 && prevSck === 1'b1 && slaveIdx > 0) begin
         slaveIdx = slaveIdx - 1;
         slaveBit = misoPat[slaveIdx];
      end
      prevSck = sck;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] modelRsp();
      logic [16:0] mask;
      mask = (17'd1 << (curLen + 1)) - 17'd1;
      return (curLoop ? curData : curPat) & mask[15:0];
   endfunction

   task automatic clearMonitor();
      riseCycle.delete();
      riseMosi.delete();
      riseSs.delete();
   endtask

   task automatic scrambleReq();
      req_data = 16'($urandom);
      req_len  = 4'($urandom);
      req_ss   = 8'($urandom);
      req_div  = 8'($urandom);
   endtask

   // Issues one request and completes the handshake
   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] len, input logic [7:0] ss,
                                input logic [7:0] div, input bit lp, input logic [15:0] pat);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!req_ready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      checkOutput("reqReadyIdle", {31'd0, req_ready}, 32'd1);
      curData = data; curLen = len; curSs = ss; curDiv = div; curLoop = lp; curPat = pat;
      loopMode = lp;
      misoPat  = pat;
      slaveIdx = len;
      slaveBit = pat[len];
      clearMonitor();
      req_valid = 1'b1;
      req_data  = data;
      req_len   = len;
      req_ss    = ss;
      req_div   = div;
      @(negedge clock);
      hsCycle   = cycleCount;
      req_valid = 1'b0;
      scrambleReq();
      checkOutput("reqReadyBusy", {31'd0, req_ready}, 32'd0);
      checkOutput("ssSetup", {24'd0, ss_n}, {24'd0, ~ss});
   endtask

   // Waits for the response, checks it against the model, then releases it
   task automatic finishReq(input int stall, input bit earlyRdy, input bit holdNext,
                            input logic [15:0] nData, input logic [3:0] nLen,
                            input logic [7:0] nSs, input logic [7:0] nDiv);
      int n, budget, mosiErr, ssErr, perErr, bad, nRise;
      logic [15:0] expRsp;
      rsp_ready = earlyRdy;
      budget = (curDiv + 1) * (2 * curLen + 4) + 20;
      n = 0;
      while (!rsp_valid && n < budget) begin
         @(negedge clock);
         n++;
      end
      expRsp = modelRsp();
      if (!rsp_valid) begin
         checkOutput("rspTimeout", 32'd0, 32'd1);
      end else begin
         checkOutput("latency", cycleCount - hsCycle, (curDiv + 1) * (2 * curLen + 4));
         checkOutput("rspData", {16'd0, rsp_data}, {16'd0, expRsp});
         checkOutput("riseCount", riseCycle.size(), curLen + 1);
         mosiErr = 0; ssErr = 0; perErr = 0;
         for (int i = 0; i < riseCycle.size() && i <= curLen; i++) begin
            if (riseMosi[i] != curData[curLen - i]) mosiErr++;
            if (riseSs[i] !== ~curSs) ssErr++;
            if (i > 0 && riseCycle[i] - riseCycle[i-1] != 2 * (curDiv + 1)) perErr++;
         end
         checkOutput("mosiBits", mosiErr, 0);
         checkOutput("ssDuring", ssErr, 0);
         checkOutput("sckPeriod", perErr, 0);
         checkOutput("pinsIdle", {22'd0, ss_n, sck, mosi}, {22'd0, 8'hFF, 1'b0, 1'b1});
      end
      if (earlyRdy) begin
         @(negedge clock);
         rsp_ready = 1'b0;
         checkOutput("rspDrop", {31'd0, rsp_valid}, 32'd0);
         checkOutput("rspDataHold", {16'd0, rsp_data}, {16'd0, expRsp});
      end else begin
         if (holdNext) begin
            req_valid = 1'b1;
            req_data  = nData;
            req_len   = nLen;
            req_ss    = nSs;
            req_div   = nDiv;
         end
         nRise = riseCycle.size();
         bad = 0;
         for (int k = 0; k < stall; k++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== expRsp || req_ready !== 1'b0 ||
                sck !== 1'b0 || riseCycle.size() != nRise) bad++;
         end
         if (stall > 0) checkOutput("stallStable", bad, 0);
         rsp_ready = 1'b1;
         @(negedge clock);
         rsp_ready = 1'b0;
         checkOutput("rspDrop", {31'd0, rsp_valid}, 32'd0);
         checkOutput("rspDataHold", {16'd0, rsp_data}, {16'd0, expRsp});
         if (holdNext) begin
            checkOutput("idleAccept", {31'd0, req_ready}, 32'd1);
            curData = nData; curLen = nLen; curSs = nSs; curDiv = nDiv; curLoop = 1'b1;
            loopMode = 1'b1;
            clearMonitor();
            @(negedge clock);
            hsCycle   = cycleCount;
            req_valid = 1'b0;
            scrambleReq();
            checkOutput("secondAccept", {23'd0, req_ready, ss_n}, {23'd0, 1'b0, ~nSs});
         end
      end
   endtask

   // Test sequence: reset/idle, directed cases, backpressure, reset abort, random
   initial begin
      int bad, guard;
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_data = '0; req_len = '0; req_ss = '0; req_div = '0;
      loopMode = 1'b0; slaveBit = 1'b0; misoPat = '0; slaveIdx = 0;
      repeat (3) @(negedge clock);
      checkOutput("resetPins", {22'd0, ss_n, sck, mosi}, {22'd0, 8'hFF, 1'b0, 1'b1});
      checkOutput("resetRsp", {15'd0, rsp_valid, rsp_data}, 32'd0);
      checkOutput("resetReady", {31'd0, req_ready}, 32'd1);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (sck !== 1'b0 || ss_n !== 8'hFF || mosi !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
      end
      checkOutput("idleHold", bad, 0);

      applyStimulus(16'hA5C3, 4'd15, 8'h01, 8'd1, 1'b1, 16'h0000);
      finishReq(0, 1'b0, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      applyStimulus(16'h00FF, 4'd7, 8'h02, 8'd0, 1'b0, 16'h0000);
      finishReq(0, 1'b0, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      applyStimulus(16'h0001, 4'd0, 8'h10, 8'd0, 1'b1, 16'h0000);
      finishReq(0, 1'b1, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      applyStimulus(16'h3C5A, 4'd9, 8'h81, 8'd0, 1'b1, 16'h0000);
      finishReq(20, 1'b0, 1'b1, 16'h8123, 4'd11, 8'h00, 8'd2);
      finishReq(0, 1'b0, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      applyStimulus(16'hBEEF, 4'd15, 8'h04, 8'd1, 1'b1, 16'h0000);
      guard = 0;
      while (riseCycle.size() < 5 && guard < 500) begin
         @(negedge clock);
         guard++;
      end
      checkOutput("abortReached", riseCycle.size() >= 5, 32'd1);
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      checkOutput("abortPins", {20'd0, req_ready, rsp_valid, ss_n, sck, mosi},
                  {20'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1});
      applyStimulus(16'h1234, 4'd12, 8'h20, 8'd1, 1'b0, 16'h5A5A);
      finishReq(0, 1'b0, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      applyStimulus(16'h0002, 4'd1, 8'h00, 8'hFF, 1'b1, 16'h0000);
      finishReq(0, 1'b0, 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);

      for (int t = 0; t < 12; t++) begin
         applyStimulus(16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom_range(0, 3)),
                       1'($urandom), 16'($urandom));
         finishReq($urandom_range(0, 3), 1'($urandom), 1'b0, 16'h0, 4'h0, 8'h0, 8'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-lane SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
- Bridges a valid/ready request/response interface on the system clock to SPI pins that drive an SPI peripheral, such as the bit-reversal device.
- One transfer per request: up to MAX_LEN bits, full duplex. Received bits are returned on a separate response channel.

Parameters:
- MAX_LEN, 16, maximum bits per transfer; LEN_W = $clog2(MAX_LEN).
- SS_W, 8, number of slave-select lines.
- DIV_W, 8, width of the clock-divider field.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high only in IDLE.
- req_data  in  MAX_LEN  TX bits, right-justified; bit n-1 is sent first.
- req_len  in  LEN_W  bit count minus 1 (0 means 1 bit, MAX_LEN-1 means MAX_LEN bits).
- req_ss  in  SS_W  one-hot select; bit i=1 asserts ss_n[i].
- req_div  in  DIV_W  half-period = req_div+1 clock cycles.
- rsp_valid  out  1  RX data valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  MAX_LEN  RX bits, right-justified; upper bits zero.
- sck  out  1  SPI clock; idles low.
- ss_n  out  SS_W  active-low selects; idle all ones.
- mosi  out  1  SPI data out; idles 1.
- miso  in  1  SPI data in.

Behaviour:
- Reset (rst_n=0 at posedge) forces the following, and aborts any transfer immediately:
  - state=IDLE
  - sck=0, ss_n=all ones, mosi=1
  - req_ready=1 (follows from IDLE), rsp_valid=0, rsp_data=0
  - all counters and latches cleared
- Handshake on posedge with req_valid&&req_ready:
  - Latch data, len, ss, div; clear the RX shift register.
  - Go to SETUP; req_ready drops the next cycle.
- The half-period counter hc counts 0..div; the "tick" fires when hc==div, after which hc returns to 0.
- States:
  - IDLE: wait for the request handshake.
  - SETUP:
    - ss_n = ~ss, sck=0, mosi = data[len].
    - On tick -> XFER_HI; raise sck and sample miso into the RX shift register on that same posedge.
  - XFER_HI: sck=1.
    - On tick with bit counter bc < len: sck=0, bc++, mosi = data[len-bc] for the new bc; -> XFER_LO.
    - On tick with bc == len: sck=0; -> HOLD.
  - XFER_LO: sck=0.
    - On tick: sck=1, sample miso; -> XFER_HI.
  - HOLD:
    - sck=0; ss_n stays asserted for one half-period.
    - On tick: ss_n=all ones, mosi=1, rsp_data = RX register; -> RSP.
  - RSP:
    - rsp_valid=1; rsp_data is stable.
    - On rsp_ready: -> IDLE, rsp_valid=0. rsp_data holds its value until the next response.
- Sampling and shift rules:
  - RX is shift-left: rx <= {rx, miso}. After n=len+1 samples, rx[n-1:0] holds the bits in order received; upper bits are 0.
  - MOSI changes only on the sck falling edge (or at SETUP entry), so it is stable across every rising edge.
- Timing:
  - Exactly len+1 rising sck edges per transfer.
  - sck period = 2*(div+1) clocks.
  - Total cycles from handshake to rsp_valid = (div+1)*(2*len+4).
  - All outputs are registered; no combinational path from miso to any output.
- Boundary conditions:
  - req_valid asserted outside IDLE is ignored; req_ready=0 there.
  - rsp_ready asserted before RSP has no effect.
  - div=0 gives sck toggling every clock; it must still meet all edge rules above.
  - div = all ones must work without counter overflow.
  - req_ss=0 is legal: the transfer runs with no select asserted.
  - Multi-hot req_ss is passed through as given.
  - Request data and parameters are latched at the handshake; later changes on req_* have no effect on the running transfer.

Test Plan:
- Reset, then idle -> sck=0, ss_n=8'hFF, mosi=1, req_ready=1, rsp_valid=0; all hold for 100 cycles.
- Loopback (miso=mosi), data=16'hA5C3, len=15, div=1, ss=8'h01:
  - ss_n=8'hFE during the transfer; 16 rising sck edges, each 4 clocks apart.
  - rsp_data=16'hA5C3, rsp_valid exactly 68 cycles after the handshake.
- miso tied 0, data=16'h00FF, len=7, div=0 -> mosi shows 1,1,1,1,1,1,1,1 at the rising edges; rsp_data=16'h0000; rsp_valid after 18 cycles.
- 1-bit transfer, len=0, loopback, data bit0=1 -> exactly one sck pulse; rsp_data=16'h0001.
- Backpressure: rsp_ready low for 20 cycles, with a new req_valid held during that time:
  - rsp_valid and rsp_data stay stable; req_ready stays 0; no sck activity.
  - After rsp_ready, the second request is accepted on the first IDLE cycle.
- rst_n pulsed low mid-transfer (after edge 5) -> the next cycle shows sck=0, ss_n=all ones, state IDLE, rsp_valid=0; a following transfer completes normally.
